// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Pipeline hazard controller: stall back-pressure, bubble/kill flushes,
// jump redirect with deferred issue, trap drain/redirect FSM, and stall
// watchdog / statistics counters.
module ysyx_23060072_pipe_ctrl #(
  parameter int STAGES       = 5,
  parameter int EX_IDX       = 2,
  parameter int XLEN         = 32,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] hold_req_i,
  input  logic              jump_flag_i,
  input  logic [XLEN-1:0]   jump_pc_i,
  input  logic              predict_hit_i,
  input  logic              trap_req_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  output logic [STAGES-1:0] hold_o,
  output logic [STAGES-1:0] flush_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              trap_ack_o,
  output logic              hold_timeout_o,
  output logic [31:0]       stall_cnt_o
);

  if (EX_IDX < 1 || EX_IDX > STAGES - 2) begin : g_bad_ex_idx
    $error("EX_IDX must lie in 1..STAGES-2");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;
  localparam int         CW      = $clog2(HOLD_TIMEOUT + 1);

  logic [1:0]        state, state_nxt;
  logic              pend_valid;
  logic [XLEN-1:0]   pend_pc, trap_pc;
  logic [CW-1:0]     hold_cnt, hold_cnt_nxt;
  logic              timeout_q;
  logic [31:0]       stall_cnt;
  logic [STAGES-1:0] hold_chain, hold_int, flush_int;
  logic              idle, jump_take, trap_take, drain_done, pend_issue;
  logic              redir_int;
  logic [XLEN-1:0]   redir_pc_int;

  assign idle       = (state == S_IDLE);
  // Trap has priority over any jump arriving in the same cycle.
  assign trap_take  = idle & trap_req_i;
  assign jump_take  = idle & ~trap_req_i & jump_flag_i & ~predict_hit_i & ~hold_chain[EX_IDX];
  assign pend_issue = idle & ~trap_req_i & ~hold_chain[0] & pend_valid;
  assign drain_done = (hold_req_i[STAGES-1:EX_IDX+1] == '0);

  // An older stage's stall back-pressures every younger stage.
  always_comb begin
    hold_chain = '0;
    for (int k = 0; k < STAGES; k++) hold_chain[k] = |(hold_req_i >> k);
  end

  // DRAIN freezes the front end up to and including the resolve stage.
  always_comb begin
    hold_int = hold_chain;
    if (state == S_DRAIN)
      for (int k = 0; k <= EX_IDX; k++) hold_int[k] = 1'b1;
  end

  // Bubbles behind a stall boundary, plus kills for jumps and trap drain.
  always_comb begin
    flush_int = '0;
    for (int k = 0; k < STAGES - 1; k++)
      if (hold_int[k] && !hold_int[k+1]) flush_int[k+1] = 1'b1;
    if (jump_take)
      for (int k = 0; k < EX_IDX; k++) flush_int[k] = 1'b1;
    if (state == S_DRAIN)
      for (int k = 0; k <= EX_IDX; k++) flush_int[k] = 1'b1;
  end

  // IF PC load source: trap handler, fresh jump, or deferred jump.
  always_comb begin
    redir_int    = 1'b0;
    redir_pc_int = '0;
    if (state == S_REDIR) begin
      redir_int    = 1'b1;
      redir_pc_int = trap_pc;
    end else if (jump_take && !hold_chain[0]) begin
      redir_int    = 1'b1;
      redir_pc_int = jump_pc_i;
    end else if (pend_issue) begin
      redir_int    = 1'b1;
      redir_pc_int = pend_pc;
    end
  end

  // Trap sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trap_req_i)     state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done)     state_nxt = S_REDIR;
      S_REDIR: if (!hold_req_i[0]) state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // Saturating consecutive-hold count.
  always_comb begin
    hold_cnt_nxt = '0;
    if (|hold_int)
      hold_cnt_nxt = (hold_cnt == CW'(HOLD_TIMEOUT)) ? hold_cnt : hold_cnt + 1'b1;
  end

  // FSM state and latched trap target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      trap_pc <= '0;
    end else begin
      state <= state_nxt;
      if (trap_take) trap_pc <= trap_pc_i;
    end
  end

  // Deferred jump: latched when IF is stalled, newest target wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (trap_take) begin
      pend_valid <= 1'b0;
    end else if (jump_take && hold_chain[0]) begin
      pend_valid <= 1'b1;
      pend_pc    <= jump_pc_i;
    end else if (jump_take || pend_issue) begin
      pend_valid <= 1'b0;
    end
  end

  // Watchdog and IF stall statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      hold_cnt  <= hold_cnt_nxt;
      if (hold_cnt_nxt == CW'(HOLD_TIMEOUT)) timeout_q <= 1'b1;
      stall_cnt <= stall_cnt + 32'(hold_int[0]);
    end
  end

  assign hold_o         = rst ? '1 : hold_int;
  assign flush_o        = rst ? '1 : flush_int;
  assign redirect_o     = ~rst & redir_int;
  assign redirect_pc_o  = rst ? '0 : redir_pc_int;
  assign trap_ack_o     = ~rst & (state == S_REDIR) & ~hold_req_i[0];
  assign hold_timeout_o = timeout_q;
  assign stall_cnt_o    = stall_cnt;

endmodule
